// File: rtl/rv_isa_pkg.sv
// +--------------------------------------------------------------------------+
// | rv_isa_pkg : RV32 opcode/funct constants, op select, states, error codes |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package rv_isa_pkg;

  localparam logic [6:0] c_OPC_OP     = 7'h33;
  localparam logic [6:0] c_OPC_OP_IMM = 7'h13;
  localparam logic [6:0] c_OPC_LOAD   = 7'h03;
  localparam logic [6:0] c_OPC_JALR   = 7'h67;
  localparam logic [6:0] c_OPC_STORE  = 7'h23;
  localparam logic [6:0] c_OPC_JAL    = 7'h6F;
  localparam logic [6:0] c_OPC_BRANCH = 7'h63;
  localparam logic [6:0] c_OPC_AUIPC  = 7'h17;

  localparam logic [2:0] c_F3_ADD  = 3'b000;
  localparam logic [2:0] c_F3_AND  = 3'b111;
  localparam logic [2:0] c_F3_OR   = 3'b110;
  localparam logic [2:0] c_F3_SLL  = 3'b001;
  localparam logic [2:0] c_F3_SLT  = 3'b010;
  localparam logic [2:0] c_F3_SRL  = 3'b101;
  localparam logic [2:0] c_F3_LW   = 3'b010;
  localparam logic [2:0] c_F3_SW   = 3'b010;
  localparam logic [2:0] c_F3_JALR = 3'b000;
  localparam logic [2:0] c_F3_BEQ  = 3'b000;
  localparam logic [2:0] c_F3_BNE  = 3'b001;

  localparam logic [6:0] c_F7_BASE = 7'h00;
  localparam logic [6:0] c_F7_SUB  = 7'h20;
  localparam logic [6:0] c_F7_MUL  = 7'h01;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_MUL   = 4'd4,  OP_ADDI = 4'd5,  OP_SLLI = 4'd6,  OP_SLTI = 4'd7,
    OP_SRLI  = 4'd8,  OP_LW   = 4'd9,  OP_SW   = 4'd10, OP_JALR = 4'd11,
    OP_JAL   = 4'd12, OP_BEQ  = 4'd13, OP_BNE  = 4'd14, OP_AUIPC = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] c_ERR_NONE  = 2'b00;
  localparam logic [1:0] c_ERR_RANGE = 2'b01;
  localparam logic [1:0] c_ERR_ALIGN = 2'b10;

endpackage

`default_nettype wire

// File: rtl/rv_field_pack.sv
// +--------------------------------------------------------------------------+
// | rv_field_pack : packs a symbolic request into an RV32 word + field checks |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv_field_pack
  import rv_isa_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_range_err,
  output logic        o_align_err
);

  logic signed [31:0] w_simm;
  logic               w_i_ok;
  logic               w_sh_ok;
  logic               w_b_ok;
  logic               w_j_ok;

  assign w_simm  = $signed(i_imm);
  assign w_i_ok  = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
  assign w_sh_ok = (i_imm[31:5] == 27'd0);
  assign w_b_ok  = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094);
  assign w_j_ok  = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574);

  always_comb begin
    o_word      = '0;
    o_range_err = 1'b0;
    o_align_err = 1'b0;
    case (op_e'(i_op))
      OP_ADD:  o_word = {c_F7_BASE, i_rs2, i_rs1, c_F3_ADD, i_rd, c_OPC_OP};
      OP_SUB:  o_word = {c_F7_SUB,  i_rs2, i_rs1, c_F3_ADD, i_rd, c_OPC_OP};
      OP_AND:  o_word = {c_F7_BASE, i_rs2, i_rs1, c_F3_AND, i_rd, c_OPC_OP};
      OP_OR:   o_word = {c_F7_BASE, i_rs2, i_rs1, c_F3_OR,  i_rd, c_OPC_OP};
      OP_MUL:  o_word = {c_F7_MUL,  i_rs2, i_rs1, c_F3_ADD, i_rd, c_OPC_OP};
      OP_ADDI: begin
        o_word      = {i_imm[11:0], i_rs1, c_F3_ADD, i_rd, c_OPC_OP_IMM};
        o_range_err = !w_i_ok;
      end
      OP_SLTI: begin
        o_word      = {i_imm[11:0], i_rs1, c_F3_SLT, i_rd, c_OPC_OP_IMM};
        o_range_err = !w_i_ok;
      end
      OP_SLLI: begin
        o_word      = {c_F7_BASE, i_imm[4:0], i_rs1, c_F3_SLL, i_rd, c_OPC_OP_IMM};
        o_range_err = !w_sh_ok;
      end
      OP_SRLI: begin
        o_word      = {c_F7_BASE, i_imm[4:0], i_rs1, c_F3_SRL, i_rd, c_OPC_OP_IMM};
        o_range_err = !w_sh_ok;
      end
      OP_LW: begin
        o_word      = {i_imm[11:0], i_rs1, c_F3_LW, i_rd, c_OPC_LOAD};
        o_range_err = !w_i_ok;
      end
      OP_JALR: begin
        o_word      = {i_imm[11:0], i_rs1, c_F3_JALR, i_rd, c_OPC_JALR};
        o_range_err = !w_i_ok;
      end
      OP_SW: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, c_F3_SW, i_imm[4:0], c_OPC_STORE};
        o_range_err = !w_i_ok;
      end
      OP_BEQ, OP_BNE: begin
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1,
                       (i_op == OP_BNE) ? c_F3_BNE : c_F3_BEQ,
                       i_imm[4:1], i_imm[11], c_OPC_BRANCH};
        o_range_err = !w_b_ok;
        o_align_err = i_imm[0];
      end
      OP_JAL: begin
        o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, c_OPC_JAL};
        o_range_err = !w_j_ok;
        o_align_err = i_imm[0];
      end
      OP_AUIPC: begin
        o_word      = {i_imm[31:12], i_rd, c_OPC_AUIPC};
        o_range_err = (i_imm[11:0] != 12'd0);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rv_program_encoder.sv
// +--------------------------------------------------------------------------+
// | rv_program_encoder : session FSM that encodes requests into imem writes  |
// | Revision           : 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv_program_encoder
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   c_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_count;
  logic                r_we;
  logic [31:0]         r_wdata;
  logic [1:0]          r_err_code;

  logic [31:0]         w_word;
  logic                w_range_err;
  logic                w_align_err;
  logic                w_bad;
  logic                w_accept;
  logic                w_last;
  logic                w_restart;
  logic [ADDR_W:0]     w_issued;

  rv_field_pack u_pack (
    .i_op        (in_op),
    .i_rd        (in_rd),
    .i_rs1       (in_rs1),
    .i_rs2       (in_rs2),
    .i_imm       (in_imm),
    .o_word      (w_word),
    .o_range_err (w_range_err),
    .o_align_err (w_align_err)
  );

  assign in_ready  = (r_state == ST_LOAD) && (r_count < c_DEPTH) && !stop;
  assign w_accept  = in_valid && in_ready;
  assign w_bad     = w_range_err || w_align_err;
  // Count lags the write pulse by a cycle, so include the in-flight write.
  assign w_issued  = r_count + {{ADDR_W{1'b0}}, r_we};
  assign w_last    = w_accept && !w_bad && (w_issued == c_DEPTH - 1'b1);
  assign w_restart = start && (r_state != ST_LOAD);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (w_accept && w_bad)   w_state_nxt = ST_ERR;
        else if (stop || w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (start) w_state_nxt = ST_LOAD;
      ST_ERR:  if (start) w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_count    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_err_code <= c_ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_accept && !w_bad;
      if (w_accept && !w_bad) r_wdata <= w_word;
      if (w_restart) begin
        r_addr     <= c_BASE;
        r_count    <= '0;
        r_err_code <= c_ERR_NONE;
      end else begin
        if (r_we) begin
          r_addr  <= r_addr + 1'b1;
          r_count <= r_count + 1'b1;
        end
        if (w_accept && w_bad)
          r_err_code <= w_range_err ? c_ERR_RANGE : c_ERR_ALIGN;
      end
    end
  end

  // Reset during the pulse cycle must keep the pending word out of memory.
  assign imem_we    = r_we && !reset;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign busy       = (r_state == ST_LOAD);
  assign done       = (r_state == ST_DONE);
  assign err        = (r_state == ST_ERR);
  assign err_code   = r_err_code;
  assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rv_program_encoder.sv
// +--------------------------------------------------------------------------+
// | tb_rv_program_encoder : directed vectors and corner sequences            |
// | Revision              : 1.0                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rv_program_encoder;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_word;
    logic [1:0]  exp_err;
  } vec_t;

  localparam int NV = 17;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A: default geometry
  logic        start, stop, in_valid;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, imem_we, busy, done, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [1:0]  err_code;
  logic [8:0]  count;

  // DUT B: four-word session starting at 2 in a 4-word space (wraps)
  logic        b_start, b_stop, b_valid;
  logic [3:0]  b_op;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [31:0] b_imm;
  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_err_code;
  logic [2:0]  b_count;

  rv_program_encoder u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
  );

  rv_program_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(2)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop),
    .in_valid(b_valid), .in_ready(b_ready), .in_op(b_op), .in_rd(b_rd),
    .in_rs1(b_rs1), .in_rs2(b_rs2), .in_imm(b_imm),
    .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code), .count(b_count)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input int i);
    in_op  = vecs[i].op;
    in_rd  = vecs[i].rd;
    in_rs1 = vecs[i].rs1;
    in_rs2 = vecs[i].rs2;
    in_imm = vecs[i].imm;
  endtask

  task automatic drive_b(input int i);
    b_op  = vecs[i].op;
    b_rd  = vecs[i].rd;
    b_rs1 = vecs[i].rs1;
    b_rs2 = vecs[i].rs2;
    b_imm = vecs[i].imm;
  endtask

  task automatic new_session();
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    #1;
  endtask

  initial begin
    //             op     rd     rs1    rs2    imm            word           err
    vecs[0]  = '{4'd5,  5'd1,  5'd0,  5'd0,  32'd5,         32'h00500093, 2'b00}; // ADDI x1,x0,5
    vecs[1]  = '{4'd0,  5'd3,  5'd1,  5'd2,  32'd0,         32'h002081B3, 2'b00}; // ADD x3,x1,x2
    vecs[2]  = '{4'd10, 5'd0,  5'd1,  5'd2,  32'd8,         32'h0020A423, 2'b00}; // SW x2,8(x1)
    vecs[3]  = '{4'd12, 5'd1,  5'd0,  5'd0,  32'd8,         32'h008000EF, 2'b00}; // JAL x1,8
    vecs[4]  = '{4'd13, 5'd0,  5'd1,  5'd2,  32'hFFFFFFFC,  32'hFE208EE3, 2'b00}; // BEQ -4
    vecs[5]  = '{4'd1,  5'd5,  5'd6,  5'd7,  32'd0,         32'h407302B3, 2'b00}; // SUB
    vecs[6]  = '{4'd6,  5'd4,  5'd4,  5'd0,  32'd31,        32'h01F21213, 2'b00}; // SLLI 31
    vecs[7]  = '{4'd15, 5'd10, 5'd0,  5'd0,  32'h12345000,  32'h12345517, 2'b00}; // AUIPC
    vecs[8]  = '{4'd9,  5'd8,  5'd2,  5'd0,  32'hFFFFFFFC,  32'hFFC12403, 2'b00}; // LW -4(x2)
    vecs[9]  = '{4'd8,  5'd1,  5'd2,  5'd0,  32'd3,         32'h00315093, 2'b00}; // SRLI 3
    vecs[10] = '{4'd4,  5'd1,  5'd2,  5'd3,  32'd0,         32'h023100B3, 2'b00}; // MUL
    vecs[11] = '{4'd12, 5'd0,  5'd0,  5'd0,  32'hFFF00000,  32'h8000006F, 2'b00}; // JAL -2^20
    vecs[12] = '{4'd13, 5'd0,  5'd1,  5'd2,  32'd3,         32'h0,        2'b10}; // BEQ odd
    vecs[13] = '{4'd5,  5'd1,  5'd0,  5'd0,  32'd2048,      32'h0,        2'b01}; // ADDI 2048
    vecs[14] = '{4'd6,  5'd1,  5'd1,  5'd0,  32'd32,        32'h0,        2'b01}; // SLLI 32
    vecs[15] = '{4'd14, 5'd0,  5'd1,  5'd2,  32'd4095,      32'h0,        2'b01}; // BNE range+odd
    vecs[16] = '{4'd15, 5'd1,  5'd0,  5'd0,  32'h00001001,  32'h0,        2'b01}; // AUIPC low bits

    reset = 1'b1; start = 0; stop = 0; in_valid = 0;
    b_start = 0; b_stop = 0; b_valid = 0;
    drive_a(0); drive_b(0);
    tick(); tick();
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst imem_we", {31'd0, imem_we}, 32'd0);
    check("rst outs", {busy, done, err, err_code, count, imem_addr}, 32'd0);
    check("rst wdata", imem_wdata, 32'd0);
    reset = 1'b0;

    // Single request per fresh session.
    for (int i = 0; i < NV; i++) begin
      new_session();
      check($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
      check($sformatf("v%0d count0", i), {23'd0, count}, 32'd0);
      check($sformatf("v%0d err clear", i), {29'd0, err, err_code}, 32'd0);
      drive_a(i); in_valid = 1'b1; #1;
      check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      tick(); in_valid = 1'b0; #1;
      if (vecs[i].exp_err == 2'b00) begin
        check($sformatf("v%0d we", i), {31'd0, imem_we}, 32'd1);
        check($sformatf("v%0d addr", i), {24'd0, imem_addr}, 32'd0);
        check($sformatf("v%0d wdata", i), imem_wdata, vecs[i].exp_word);
        tick();
        check($sformatf("v%0d we off", i), {31'd0, imem_we}, 32'd0);
        check($sformatf("v%0d count1", i), {23'd0, count}, 32'd1);
        check($sformatf("v%0d addr adv", i), {24'd0, imem_addr}, 32'd1);
      end else begin
        check($sformatf("v%0d no we", i), {31'd0, imem_we}, 32'd0);
        check($sformatf("v%0d err", i), {31'd0, err}, 32'd1);
        check($sformatf("v%0d err_code", i), {30'd0, err_code}, {30'd0, vecs[i].exp_err});
        tick();
        check($sformatf("v%0d count stays", i), {23'd0, count}, 32'd0);
      end
    end

    // Back-to-back ADDI, ADD, SW, JAL with no bubbles.
    new_session();
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        drive_a(k); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 4) check($sformatf("b2b ready %0d", k), {31'd0, in_ready}, 32'd1);
      if (k > 0) begin
        check($sformatf("b2b we %0d", k - 1), {31'd0, imem_we}, 32'd1);
        check($sformatf("b2b addr %0d", k - 1), {24'd0, imem_addr}, k - 1);
        check($sformatf("b2b wdata %0d", k - 1), imem_wdata, vecs[k-1].exp_word);
      end
      tick();
    end
    check("b2b count", {23'd0, count}, 32'd4);
    check("b2b we off", {31'd0, imem_we}, 32'd0);

    // Start inside LOAD is ignored; stop alongside valid blocks the request.
    start = 1'b1; tick(); start = 1'b0; #1;
    check("start in LOAD count", {23'd0, count}, 32'd4);
    drive_a(0); in_valid = 1'b1; stop = 1'b1; #1;
    check("stop blocks ready", {31'd0, in_ready}, 32'd0);
    tick(); in_valid = 1'b0; stop = 1'b0; #1;
    check("stop no we", {31'd0, imem_we}, 32'd0);
    check("stop done", {30'd0, done, busy}, 32'd2);
    check("stop count", {23'd0, count}, 32'd4);

    // DEPTH=4 instance: five requests, four writes at 2,3,0,1.
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        drive_b(k % 4); b_valid = 1'b1;
      end else begin
        b_valid = 1'b0;
      end
      #1;
      if (k < 5) check($sformatf("full ready %0d", k), {31'd0, b_ready}, (k < 4) ? 32'd1 : 32'd0);
      if (k > 0 && k < 5) begin
        check($sformatf("full we %0d", k - 1), {31'd0, b_we}, 32'd1);
        check($sformatf("full addr %0d", k - 1), {30'd0, b_addr}, (k + 1) % 4);
        check($sformatf("full wdata %0d", k - 1), b_wdata, vecs[k-1].exp_word);
      end
      if (k == 4) check("full done with 4th we", {31'd0, b_done}, 32'd1);
      if (k == 5) check("full no 5th write", {31'd0, b_we}, 32'd0);
      tick();
    end
    check("full count", {29'd0, b_count}, 32'd4);
    check("full done", {30'd0, b_done, b_busy}, 32'd2);

    // Reset in the cycle after an accept drops the write.
    new_session();
    drive_a(0); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    reset = 1'b1; #1;
    check("rst drop we", {31'd0, imem_we}, 32'd0);
    tick(); reset = 1'b0; #1;
    check("rst2 we", {31'd0, imem_we}, 32'd0);
    check("rst2 outs", {in_ready, busy, done, err, err_code, count, imem_addr}, 32'd0);
    check("rst2 wdata", imem_wdata, 32'd0);
    tick();
    check("rst2 idle count", {23'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
